// File: rtl/me_mem_access_pkg.sv
// ---------------------------------------------------------------------------
// me_mem_access_pkg
// Shared definitions for the memory-stage data-access unit:
//   - load kind constants (funct3 encoding)
//   - store byte-mask constants (unshifted)
//   - access state machine encoding
//   - helper that classifies an access as misaligned for its size
// ---------------------------------------------------------------------------
package me_mem_access_pkg;

    // Load kinds, funct3 encoding
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Store masks before lane shifting
    localparam logic [3:0] ST_NONE = 4'b0000;
    localparam logic [3:0] ST_SB   = 4'b0001;
    localparam logic [3:0] ST_SH   = 4'b0011;
    localparam logic [3:0] ST_SW   = 4'b1111;

    // Access state machine
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } me_state_e;

    // True when the access size does not fit its natural alignment:
    // halfwords at an odd offset, words at any non-zero offset.
    function automatic logic is_misaligned(
        input logic       is_load,
        input logic [2:0] ld_type,
        input logic [3:0] st_mask,
        input logic [1:0] offset
    );
        logic result;
        result = 1'b0;
        if (is_load) begin
            case (ld_type)
                LD_LH, LD_LHU: result = offset[0];
                LD_LW:         result = (offset != 2'b00);
                default:       result = 1'b0;
            endcase
        end else begin
            case (st_mask)
                ST_SH:   result = offset[0];
                ST_SW:   result = (offset != 2'b00);
                default: result = 1'b0;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/me_mem_access_load_align.sv
// ---------------------------------------------------------------------------
// me_mem_access_load_align
// Combinational load lane extraction: picks the addressed byte/halfword out of
// a read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata_i    [31:0] read word from memory
//   offset_i   [1:0]  byte offset within the word (addr[1:0])
//   ld_type_i  [2:0]  load kind (funct3)
//   data_o     [31:0] extended load result
// Lanes are taken after a plain right shift, so an access that runs past the
// top of the word is truncated rather than wrapped.
// ---------------------------------------------------------------------------
module me_mem_access_load_align
    import me_mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted_s;

    // Shift the addressed lane down to bit 0, then extend per load kind
    always_comb begin
        shifted_s = rdata_i >> {offset_i, 3'b000};
        case (ld_type_i)
            LD_LB:   data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LD_LH:   data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LD_LW:   data_o = shifted_s;
            LD_LBU:  data_o = {24'h000000, shifted_s[7:0]};
            LD_LHU:  data_o = {16'h0000, shifted_s[15:0]};
            default: data_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/me_mem_access.sv
// ---------------------------------------------------------------------------
// me_mem_access
// Memory-stage data-access unit. Turns the held ME-stage control into a single
// request/acknowledge transaction on the data-memory port, stalls the pipeline
// until it completes, and returns the aligned/extended load result.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When defined, adds misalign_ME; misaligned halfword/word accesses skip the
//   memory request entirely and finish with load_data_ME = 0.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   alu_out_ME    [31:0] effective address
//   store_data_ME [31:0] unshifted store data
//   mem_write_ME  [3:0]  unshifted store mask (0000 = no store)
//   mem_to_reg_ME        instruction is a load
//   ld_type_ME    [2:0]  load kind (funct3)
//   advance_ME           instruction leaves ME at this edge
//   mem_req/mem_addr/mem_we/mem_wdata  data-memory request
//   mem_ack/mem_rdata    memory completion and read word
//   load_data_ME  [31:0] extended load result to ME/WB
//   stall_ME             freeze upstream pipeline registers
//   bus_err              one-cycle pulse when the access times out
//   misalign_ME          (MISALIGN_TRAP_EN only) misaligned access trapped
// ---------------------------------------------------------------------------
module me_mem_access
    import me_mem_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_ME,
    input  logic [31:0] store_data_ME,
    input  logic [3:0]  mem_write_ME,
    input  logic        mem_to_reg_ME,
    input  logic [2:0]  ld_type_ME,
    input  logic        advance_ME,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data_ME,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_ME,
`endif
    output logic        stall_ME,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    me_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             bus_err_q, bus_err_d;

    logic             access_s;
    logic [1:0]       offset_s;
    logic [31:0]      aligned_s;

`ifdef MISALIGN_TRAP_EN
    logic             misalign_q, misalign_d;
    logic             misaligned_s;
`endif

    assign access_s = mem_to_reg_ME | (|mem_write_ME);
    assign offset_s = alu_out_ME[1:0];

    me_mem_access_load_align u_load_align (
        .rdata_i   (mem_rdata),
        .offset_i  (offset_s),
        .ld_type_i (ld_type_ME),
        .data_o    (aligned_s)
    );

`ifdef MISALIGN_TRAP_EN
    assign misaligned_s = is_misaligned(mem_to_reg_ME, ld_type_ME, mem_write_ME, offset_s);
`endif

    // Next-state, timeout counter and load result capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    cnt_d = {CNT_W{1'b0}};
`ifdef MISALIGN_TRAP_EN
                    if (misaligned_s) begin
                        // Trapped access never reaches the memory port
                        state_d     = ST_DONE;
                        load_data_d = 32'h0000_0000;
                        misalign_d  = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (mem_to_reg_ME) begin
                        load_data_d = aligned_s;
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Give up: flag the error and return a zero result
                    state_d     = ST_DONE;
                    load_data_d = 32'h0000_0000;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Stay here while the same instruction is held so it is not re-issued
                if (advance_ME) begin
                    state_d = ST_IDLE;
`ifdef MISALIGN_TRAP_EN
                    misalign_d = 1'b0;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            load_data_q <= 32'h0000_0000;
            bus_err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    // Memory port and stall outputs decoded from the held state
    always_comb begin
        mem_req   = (state_q == ST_REQ);
        mem_addr  = {alu_out_ME[31:2], 2'b00};
        mem_wdata = store_data_ME << {offset_s, 3'b000};
        if (state_q == ST_REQ) begin
            mem_we = mem_write_ME << offset_s;
        end else begin
            mem_we = 4'b0000;
        end
        // The IDLE term stalls in the same cycle the access appears
        stall_ME = ((state_q == ST_IDLE) & access_s) | (state_q == ST_REQ);
    end

    assign load_data_ME = load_data_q;
    assign bus_err      = bus_err_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_ME  = misalign_q & (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_me_mem_access.sv
// ---------------------------------------------------------------------------
// tb_me_mem_access
// Directed self-checking bench for me_mem_access (ACK_TIMEOUT = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_me_mem_access;
    import me_mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] alu_out_ME;
    logic [31:0] store_data_ME;
    logic [3:0]  mem_write_ME;
    logic        mem_to_reg_ME;
    logic [2:0]  ld_type_ME;
    logic        advance_ME;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] load_data_ME;
    logic        stall_ME;
    logic        bus_err;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_ME;
`endif

    int total_checks;
    int failed_checks;

    me_mem_access #(
        .ACK_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_out_ME    (alu_out_ME),
        .store_data_ME (store_data_ME),
        .mem_write_ME  (mem_write_ME),
        .mem_to_reg_ME (mem_to_reg_ME),
        .ld_type_ME    (ld_type_ME),
        .advance_ME    (advance_ME),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .load_data_ME  (load_data_ME),
`ifdef MISALIGN_TRAP_EN
        .misalign_ME   (misalign_ME),
`endif
        .stall_ME      (stall_ME),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) else begin
            failed_checks++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full load with ack in the first REQ cycle; checks the result in DONE
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] ldt,
                           input logic [31:0] rdata, input logic [31:0] exp);
        alu_out_ME    = addr;
        ld_type_ME    = ldt;
        mem_to_reg_ME = 1'b1;
        mem_write_ME  = 4'b0000;
        tick();                 // -> REQ
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();                 // -> DONE
        mem_ack   = 1'b0;
        @(negedge clk);
        chk(tag, load_data_ME, exp);
        advance_ME = 1'b1;
        tick();                 // -> IDLE
        advance_ME    = 1'b0;
        mem_to_reg_ME = 1'b0;
    endtask

    initial begin
        total_checks  = 0;
        failed_checks = 0;
        rst           = 1'b1;
        alu_out_ME    = 32'h0;
        store_data_ME = 32'h0;
        mem_write_ME  = 4'b0000;
        mem_to_reg_ME = 1'b0;
        ld_type_ME    = LD_LW;
        advance_ME    = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'h0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_req",   {31'h0, mem_req},  32'h0);
        chk("rst_stall", {31'h0, stall_ME}, 32'h0);
        chk("rst_berr",  {31'h0, bus_err},  32'h0);
        chk("rst_we",    {28'h0, mem_we},   32'h0);
        chk("rst_load",  load_data_ME,      32'h0);
        tick();
        rst = 1'b0;
        tick();

        // LW 0x100, ack in first REQ cycle: two stall cycles
        alu_out_ME    = 32'h0000_0100;
        mem_to_reg_ME = 1'b1;
        ld_type_ME    = LD_LW;
        @(negedge clk);
        chk("lw_idle_stall", {31'h0, stall_ME}, 32'h1);
        chk("lw_idle_req",   {31'h0, mem_req},  32'h0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lw_req_req",   {31'h0, mem_req},  32'h1);
        chk("lw_req_stall", {31'h0, stall_ME}, 32'h1);
        chk("lw_req_addr",  mem_addr,          32'h0000_0100);
        chk("lw_req_we",    {28'h0, mem_we},   32'h0);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("lw_done_stall", {31'h0, stall_ME}, 32'h0);
        chk("lw_done_req",   {31'h0, mem_req},  32'h0);
        chk("lw_done_data",  load_data_ME,      32'hDEAD_BEEF);
        advance_ME = 1'b1;
        tick();
        advance_ME    = 1'b0;
        mem_to_reg_ME = 1'b0;

        // SB at 0x103
        alu_out_ME    = 32'h0000_0103;
        store_data_ME = 32'h0000_00A5;
        mem_write_ME  = ST_SB;
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("sb_we",    {28'h0, mem_we},   32'h8);
        chk("sb_wdata", mem_wdata,         32'hA500_0000);
        chk("sb_addr",  mem_addr,          32'h0000_0100);
        chk("sb_req",   {31'h0, mem_req},  32'h1);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("sb_load_kept", load_data_ME, 32'hDEAD_BEEF);
        advance_ME = 1'b1;
        tick();
        advance_ME = 1'b0;

        // SW at 0x102 is truncated to the upper two lanes
        alu_out_ME    = 32'h0000_0102;
        store_data_ME = 32'h1122_3344;
        mem_write_ME  = ST_SW;
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("sw_mis_we",    {28'h0, mem_we}, 32'hC);
        chk("sw_mis_wdata", mem_wdata,       32'h3344_0000);
        tick();
        mem_ack = 1'b0;
        advance_ME = 1'b1;
        tick();
        advance_ME   = 1'b0;
        mem_write_ME = 4'b0000;

        // Lane extraction and extension
        do_load("lb_sext",  32'h0000_0101, LD_LB,  32'h0000_8000, 32'hFFFF_FF80);
        do_load("lbu_zext", 32'h0000_0101, LD_LBU, 32'h0000_8000, 32'h0000_0080);
        do_load("lhu_hi",   32'h0000_0102, LD_LHU, 32'hBEEF_0000, 32'h0000_BEEF);
        do_load("lh_hi",    32'h0000_0102, LD_LH,  32'hBEEF_0000, 32'hFFFF_BEEF);
        do_load("lw_mis",   32'h0000_0101, LD_LW,  32'hAABB_CCDD, 32'h00AA_BBCC);

        // Timeout: no ack, four REQ cycles then one bus_err pulse
        alu_out_ME    = 32'h0000_0200;
        mem_to_reg_ME = 1'b1;
        ld_type_ME    = LD_LW;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("to_req%0d", i), {31'h0, mem_req}, 32'h1);
            chk($sformatf("to_berr%0d", i), {31'h0, bus_err}, 32'h0);
        end
        tick();
        @(negedge clk);
        chk("to_done_req",   {31'h0, mem_req},  32'h0);
        chk("to_done_berr",  {31'h0, bus_err},  32'h1);
        chk("to_done_load",  load_data_ME,      32'h0);
        chk("to_done_stall", {31'h0, stall_ME}, 32'h0);

        // Held in DONE: no re-issue, bus_err does not repeat
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("hold_req%0d", i),   {31'h0, mem_req},  32'h0);
            chk($sformatf("hold_stall%0d", i), {31'h0, stall_ME}, 32'h0);
            chk($sformatf("hold_berr%0d", i),  {31'h0, bus_err},  32'h0);
        end

        // Advance, then a fresh transaction starts
        advance_ME = 1'b1;
        tick();
        advance_ME = 1'b0;
        @(negedge clk);
        chk("fresh_idle_stall", {31'h0, stall_ME}, 32'h1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("fresh_req", {31'h0, mem_req}, 32'h1);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("fresh_load", load_data_ME, 32'h1234_5678);
        advance_ME = 1'b1;
        tick();
        advance_ME = 1'b0;

        // Reset during REQ, late ack ignored
        alu_out_ME = 32'h0000_0300;
        tick();
        @(negedge clk);
        chk("rreq_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        mem_to_reg_ME = 1'b0;
        mem_ack       = 1'b1;
        mem_rdata     = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rreq_after_req",   {31'h0, mem_req},  32'h0);
        chk("rreq_after_stall", {31'h0, stall_ME}, 32'h0);
        chk("rreq_after_load",  load_data_ME,      32'h0);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req",  {31'h0, mem_req}, 32'h0);
        chk("late_ack_load", load_data_ME,     32'h0);
        chk("late_ack_berr", {31'h0, bus_err}, 32'h0);

        $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/me_mem_access.md
Name: me_mem_access

Overview:
- Memory-stage data-access unit; the consumer of the EX/ME pipeline register outputs.
- Turns the held ME-stage control (address, store data, byte-write mask, load flag) into one request/acknowledge transaction on the data-memory port.
- Holds a stall request to the hazard unit until the transaction completes.
- Delivers the aligned, extended load result to the ME/WB register.

Parameters:
ACK_TIMEOUT, 16, cycles to wait for mem_ack before abandoning the access (range 1..255)
CNT_W, 8, width of the timeout counter; must hold ACK_TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
alu_out_ME  input  32  effective address
store_data_ME  input  32  store data, unshifted (byte/half in low bits)
mem_write_ME  input  4  store mask, unshifted: 0001 SB, 0011 SH, 1111 SW, 0000 no store
mem_to_reg_ME  input  1  instruction is a load
ld_type_ME  input  3  load kind, funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
advance_ME  input  1  ME/WB register enable this cycle (the instruction leaves ME at the edge)
mem_req  output  1  data-memory request
mem_addr  output  32  word address, {alu_out_ME[31:2],2'b00}
mem_we  output  4  byte write enables, shifted by addr[1:0]; 0000 for loads
mem_wdata  output  32  store data shifted to byte lane
mem_ack  input  1  memory accepted/completed the request this cycle
mem_rdata  input  32  read word, valid when mem_ack=1
load_data_ME  output  32  extended load result to ME/WB
stall_ME  output  1  to hazard unit: freeze PC/IF/ID/EX/ME registers
bus_err  output  1  one-cycle pulse: access abandoned on timeout

Behaviour:
- Access pending: access = mem_to_reg_ME | (|mem_write_ME).
- State machine IDLE, REQ, DONE; reset state IDLE.
- Reset values: mem_req=0, mem_we=0, load_data_ME=0, bus_err=0, stall_ME=0, counter=0.
- IDLE:
  - access=1 -> stall_ME=1 (combinational), next REQ, counter cleared.
  - access=0 -> stall_ME=0, stay IDLE.
- REQ:
  - mem_req=1; mem_addr/mem_we/mem_wdata driven from the held ME inputs; stall_ME=1.
  - mem_ack=1 -> register load_data_ME (if load), next DONE.
  - No ack -> counter increments; when counter reaches ACK_TIMEOUT-1 without ack -> load_data_ME=0, bus_err pulses for the next cycle, next DONE.
- DONE:
  - stall_ME=0, mem_req=0.
  - advance_ME=1 -> IDLE.
  - advance_ME=0 -> stay DONE (no re-issue while the same instruction is held).
- Minimum latency with ack in the first REQ cycle: 2 stall cycles. load_data_ME is valid in DONE.
- Lane rules, with o=addr[1:0]:
  - mem_we = mem_write_ME << o.
  - mem_wdata = store_data_ME << (8*o).
  - Load: byte = rdata >> (8*o) [7:0]; half = rdata >> (8*o) [15:0]; sign- or zero-extend per ld_type_ME.
- Misaligned addresses (half at o=3, word at o!=0) are truncated by the shift; no wrap into the adjacent word.
- mem_ack while not in REQ is ignored.
- Timeout counter saturates; it never wraps.
- rst mid-transaction: synchronous return to IDLE, mem_req drops the same edge; an in-flight ack in the next cycle is ignored.
- load_data_ME holds its value outside DONE until the next completed load; stores leave it unchanged.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_ME (1 bit), asserted in DONE for an access with LH/LHU/SH at o odd, or LW/SW at o!=0.
  - Such an access skips REQ: IDLE -> DONE directly, no mem_req, no write; load_data_ME=0.
- Undefined: no port; misaligned accesses proceed with truncating lane rules.

Decomposition:
- Shared package:
  - ld_type funct3 constants (LB, LH, LW, LBU, LHU).
  - Store mask constants (SB/SH/SW masks).
  - State encoding constants for IDLE/REQ/DONE.
- One sub-module natural: load_align (combinational: rdata, offset, ld_type -> extended 32-bit result), reused by any future cache path.

Test Plan:
- LW at addr 0x100, memory acks in the first REQ cycle with rdata 0xDEADBEEF -> stall_ME high exactly 2 cycles, load_data_ME=0xDEADBEEF in DONE, mem_we=0000.
- SB at addr 0x103, store_data_ME=0x000000A5 -> mem_we=1000, mem_wdata=0xA5000000, mem_addr=0x100; load_data_ME unchanged.
- LB at addr 0x101 with rdata 0x0000_8000 -> load_data_ME=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 with rdata 0xBEEF0000 -> 0x0000BEEF.
- ACK_TIMEOUT=4, mem_ack never asserted -> mem_req high 4 cycles, bus_err one pulse, load_data_ME=0, stall_ME released in DONE.
- advance_ME held low 3 cycles in DONE -> no second mem_req, state stays DONE; advance_ME=1 then a new access -> a fresh transaction.
- rst asserted during REQ -> next edge mem_req=0, stall_ME=0, state IDLE; an ack arriving the following cycle has no effect.
